// File: rtl/definitions_pkg.sv
// Shared definitions for the 3x3 convolution engine: frame defaults, filter
// modes, engine states and the three kernels.
package definitions_pkg;

  localparam int IMAGE_HEIGHT = 512;
  localparam int PIXEL_W      = 8;

  typedef enum logic [1:0] {
    GAUSS     = 2'b00,
    SOBEL_X   = 2'b01,
    SOBEL_Y   = 2'b10,
    SOBEL_MAG = 2'b11
  } conv_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } engine_state_e;

  typedef int kernel_t [3][3];

  // Row 0 is the oldest row, column 0 the oldest column of the window.
  localparam kernel_t K_GAUSS   = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
  localparam kernel_t K_SOBEL_X = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  localparam kernel_t K_SOBEL_Y = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

endpackage

// File: rtl/conv_line_buffer.sv
// Two-row line storage plus a 3x3 sliding window; everything advances only on
// an accepted input pixel, so an output stall freezes it for free.
module conv_line_buffer #(
  parameter int IMAGE_WIDTH = 512,
  parameter int PIXEL_W     = 8,
  parameter int COL_W       = $clog2(IMAGE_WIDTH)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [COL_W-1:0]     col,
  input  logic [PIXEL_W-1:0]   pixel,
  output logic [9*PIXEL_W-1:0] window
);

  logic [PIXEL_W-1:0] row_top [IMAGE_WIDTH];
  logic [PIXEL_W-1:0] row_mid [IMAGE_WIDTH];
  logic [PIXEL_W-1:0] win [3][3];

  // The new column enters on the right: {two rows ago, previous row, incoming}.
  always_ff @(posedge clk) begin
    if (en) begin
      row_top[col] <= row_mid[col];
      row_mid[col] <= pixel;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= row_top[col];
      win[1][2] <= row_mid[col];
      win[2][2] <= pixel;
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign window[(r*3+c)*PIXEL_W +: PIXEL_W] = win[r][c];
    end
  end

endmodule

// File: rtl/kernel_conv_engine.sv
// Streaming 3x3 convolution (gaussian / sobel) over a raster frame with a
// window stage, a compute stage and an output register.
module kernel_conv_engine #(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512,
  parameter int PIXEL_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIXEL_W-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [PIXEL_W-1:0] m_data,
  output logic               busy_o,
  output logic               done_o
);

  import definitions_pkg::conv_mode_e;
  import definitions_pkg::GAUSS;
  import definitions_pkg::SOBEL_X;
  import definitions_pkg::SOBEL_Y;
  import definitions_pkg::SOBEL_MAG;
  import definitions_pkg::engine_state_e;
  import definitions_pkg::ST_IDLE;
  import definitions_pkg::ST_RUN;
  import definitions_pkg::ST_FLUSH;
  import definitions_pkg::K_GAUSS;
  import definitions_pkg::K_SOBEL_X;
  import definitions_pkg::K_SOBEL_Y;

  localparam int COL_W = $clog2(IMAGE_WIDTH);
  localparam int ROW_W = $clog2(IMAGE_HEIGHT);
  localparam int GS_W  = PIXEL_W + 4;
  localparam int GD_W  = PIXEL_W + 3;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);

  engine_state_e state, state_nx;
  conv_mode_e    mode_q;

  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic                   win_valid, sum_valid;
  logic                   advance, accept, last_pixel, last_out, centre_ok;
  logic [9*PIXEL_W-1:0]   window;
  logic [GS_W-1:0]        gsum_d, gsum_q;
  logic signed [GD_W-1:0] gx_d, gx_q, gy_d, gy_q;
  logic [GD_W-1:0]        abs_x, abs_y;
  logic [GD_W:0]          mag;
  logic [PIXEL_W-1:0]     result;
  int                     acc_g, acc_x, acc_y, px;

  // Handshakes: a beat moves only when valid && ready are both high at a rising
  // edge; valid never waits on ready, and m_data is frozen while m_valid && !m_ready.
  assign advance    = !m_valid || m_ready;
  assign s_ready    = (state == ST_RUN) && advance;
  assign accept     = s_valid && s_ready;
  assign busy_o     = (state != ST_IDLE);
  assign last_pixel = (row == LAST_ROW) && (col == LAST_COL);
  assign centre_ok  = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign last_out   = (state == ST_FLUSH) && m_valid && m_ready && !win_valid && !sum_valid;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start_i) state_nx = ST_RUN;
      ST_RUN:   if (accept && last_pixel) state_nx = ST_FLUSH;
      ST_FLUSH: if (last_out) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= GAUSS;
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      sum_valid <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      done_o    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_o <= last_out;
      if (state == ST_IDLE && start_i) begin
        mode_q <= conv_mode_e'(mode_i);
        col    <= '0;
        row    <= '0;
      end else if (accept) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (advance) begin
        win_valid <= accept && centre_ok;
        sum_valid <= win_valid;
        m_valid   <= sum_valid;
        if (sum_valid) m_data <= result;
      end
    end
  end

  conv_line_buffer #(
    .IMAGE_WIDTH(IMAGE_WIDTH),
    .PIXEL_W    (PIXEL_W),
    .COL_W      (COL_W)
  ) u_line_buffer (
    .clk   (clk),
    .en    (accept),
    .col   (col),
    .pixel (s_data),
    .window(window)
  );

  always_comb begin
    acc_g = 0;
    acc_x = 0;
    acc_y = 0;
    px    = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px    = int'(window[(r*3+c)*PIXEL_W +: PIXEL_W]);
        acc_g = acc_g + K_GAUSS[r][c] * px;
        acc_x = acc_x + K_SOBEL_X[r][c] * px;
        acc_y = acc_y + K_SOBEL_Y[r][c] * px;
      end
    end
    gsum_d = acc_g[GS_W-1:0];
    gx_d   = acc_x[GD_W-1:0];
    gy_d   = acc_y[GD_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (advance && win_valid) begin
      gsum_q <= gsum_d;
      gx_q   <= gx_d;
      gy_q   <= gy_d;
    end
  end

  // Sobel results saturate to full scale once any bit above PIXEL_W is set.
  always_comb begin
    abs_x  = gx_q[GD_W-1] ? -gx_q : gx_q;
    abs_y  = gy_q[GD_W-1] ? -gy_q : gy_q;
    mag    = {1'b0, abs_x} + {1'b0, abs_y};
    result = '0;
    case (mode_q)
      GAUSS:     result = gsum_q[GS_W-1:4];
      SOBEL_X:   result = (|abs_x[GD_W-1:PIXEL_W]) ? '1 : abs_x[PIXEL_W-1:0];
      SOBEL_Y:   result = (|abs_y[GD_W-1:PIXEL_W]) ? '1 : abs_y[PIXEL_W-1:0];
      SOBEL_MAG: result = (|mag[GD_W:PIXEL_W]) ? '1 : mag[PIXEL_W-1:0];
      default:   result = '0;
    endcase
  end

endmodule

// File: tb/tb_kernel_conv_engine.sv
// Bench for kernel_conv_engine on an 8x6 frame: directed images, random images
// with input gaps and output stalls, ignored start/mode, and mid-frame reset.
module tb_kernel_conv_engine;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int PW   = 8;
  localparam int NPIX = W * H;
  localparam int NOUT = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst_n, start_i, s_valid, s_ready, m_valid, m_ready, busy_o, done_o;
  logic [1:0]    mode_i;
  logic [PW-1:0] s_data, m_data;

  kernel_conv_engine #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .PIXEL_W     (PW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .mode_i (mode_i),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  logic [PW-1:0] pix [NPIX];
  logic [PW-1:0] exp_q [$];
  logic [PW-1:0] got_q [$];
  int n_checks, n_pass;
  int done_cnt, first_mv_cyc, acc_cyc, sready_viol, hold_viol, busy_at_done;
  bit timed_out, aborted;

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] ref_pixel(input int mode, input int r, input int c);
    int gs, gx, gy, res, wr, wc;
    gs = 0; gx = 0; gy = 0; res = 0;
    for (int d = -1; d <= 1; d++) begin
      wr = (d == 0) ? 2 : 1;
      for (int e = -1; e <= 1; e++) begin
        wc = (e == 0) ? 2 : 1;
        gs += wr * wc * int'(pix[(r+d)*W + c + e]);
      end
      gx += wr * (int'(pix[(r+d)*W + c + 1]) - int'(pix[(r+d)*W + c - 1]));
      gy += wr * (int'(pix[(r+1)*W + c + d]) - int'(pix[(r-1)*W + c + d]));
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (mode)
      0:       res = gs / 16;
      1:       res = gx;
      2:       res = gy;
      default: res = gx + gy;
    endcase
    if (res > (1 << PW) - 1) res = (1 << PW) - 1;
    return PW'(res);
  endfunction

  task automatic build_expected(input int mode);
    exp_q.delete();
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++)
        exp_q.push_back(ref_pixel(mode, r, c));
  endtask

  task automatic fill_random;
    for (int i = 0; i < NPIX; i++) pix[i] = PW'($urandom_range(0, (1 << PW) - 1));
  endtask

  // ---------------- driver / monitor ----------------
  task automatic run_frame(input logic [1:0] mode, input int gap_pct, input int stall_at,
                           input int abort_at, input bit toggle);
    int idx, cyc, stall_left, post;
    bit prev_hold, in_acc;
    logic [PW-1:0] prev_data;
    got_q.delete();
    done_cnt = 0; first_mv_cyc = -1; acc_cyc = -1; sready_viol = 0; hold_viol = 0;
    busy_at_done = 1; timed_out = 0; aborted = 0;
    @(negedge clk);
    start_i = 1'b1; mode_i = mode; s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk);
    idx = 0; cyc = 0; stall_left = 0; post = 0; prev_hold = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      start_i = (toggle && !done_o && done_cnt == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      mode_i  = toggle ? 2'($urandom_range(0, 3)) : mode;
      if (idx == abort_at) begin
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1; start_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        aborted = 1;
        return;
      end
      if (idx < NPIX) begin
        s_valid = ($urandom_range(0, 99) >= gap_pct);
        s_data  = pix[idx];
      end else begin
        s_valid = 1'b0;
        s_data  = PW'($urandom);
      end
      if (cyc == stall_at) stall_left = 10;
      m_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (done_o) begin done_cnt++; busy_at_done = busy_o; end
      if (prev_hold && (!m_valid || m_data !== prev_data)) hold_viol++;
      if (m_valid && !m_ready && s_ready) sready_viol++;
      if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
      if (m_valid && m_ready) got_q.push_back(m_data);
      in_acc = s_valid && s_ready;
      if (in_acc && idx == 2*W + 2) acc_cyc = cyc + 1;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      @(posedge clk);
      cyc++;
      if (in_acc) idx++;
      if (done_cnt > 0) post++;
      if (post >= 4) break;
      if (cyc > 1500) begin timed_out = 1; break; end
    end
    s_valid = 1'b0;
    start_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; start_i = 1'b0; mode_i = 2'b00; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %0b expected 0", s_ready); else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %0b expected 0", m_valid); else n_pass++;
    n_checks++; if (m_data !== '0) $display("FAIL reset_m_data: got %0d expected 0", m_data); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy_o); else n_pass++;
    n_checks++; if (done_o !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done_o); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_gauss_const;
    for (int i = 0; i < NPIX; i++) pix[i] = PW'(100);
    run_frame(2'b00, 0, -1, -1, 0);
    n_checks++; if (timed_out) $display("FAIL gauss_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (got_q.size() != NOUT) $display("FAIL gauss_count: got %0d expected %0d", got_q.size(), NOUT); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== PW'(100)) $display("FAIL gauss_pixel[%0d]: got %0d expected 100", i, got_q[i]); else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL gauss_done: got %0d pulses expected 1", done_cnt); else n_pass++;
    n_checks++; if (first_mv_cyc - acc_cyc != 2) $display("FAIL gauss_latency: got %0d expected 2", first_mv_cyc - acc_cyc); else n_pass++;
    n_checks++; if (busy_at_done != 0) $display("FAIL gauss_busy_at_done: got %0d expected 0", busy_at_done); else n_pass++;
  endtask

  task automatic test_sobel_edge;
    logic [PW-1:0] e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix[r*W + c] = (c >= 4) ? PW'(200) : PW'(0);
    run_frame(2'b01, 0, -1, -1, 0);
    n_checks++; if (got_q.size() != NOUT) $display("FAIL sobx_count: got %0d expected %0d", got_q.size(), NOUT); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      e = ((i % (W-2)) == 2 || (i % (W-2)) == 3) ? PW'(255) : PW'(0);
      n_checks++; if (got_q[i] !== e) $display("FAIL sobx_pixel[%0d]: got %0d expected %0d", i, got_q[i], e); else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL sobx_done: got %0d pulses expected 1", done_cnt); else n_pass++;
    run_frame(2'b10, 0, -1, -1, 0);
    n_checks++; if (got_q.size() != NOUT) $display("FAIL soby_count: got %0d expected %0d", got_q.size(), NOUT); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== PW'(0)) $display("FAIL soby_pixel[%0d]: got %0d expected 0", i, got_q[i]); else n_pass++;
    end
  endtask

  task automatic test_ramp_mag;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix[r*W + c] = PW'(r * 10);
    run_frame(2'b11, 0, -1, -1, 0);
    n_checks++; if (got_q.size() != NOUT) $display("FAIL ramp_count: got %0d expected %0d", got_q.size(), NOUT); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== PW'(80)) $display("FAIL ramp_pixel[%0d]: got %0d expected 80", i, got_q[i]); else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL ramp_done: got %0d pulses expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_stall_random;
    int mode;
    for (int k = 0; k < 4; k++) begin
      mode = k;
      fill_random();
      build_expected(mode);
      run_frame(2'(mode), 25, 30, -1, 0);
      n_checks++; if (timed_out) $display("FAIL stall_timeout[m%0d]: got timeout expected done", mode); else n_pass++;
      n_checks++; if (got_q.size() != NOUT) $display("FAIL stall_count[m%0d]: got %0d expected %0d", mode, got_q.size(), NOUT); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i])
          $display("FAIL stall_pixel[m%0d][%0d]: got %0d expected %0d", mode, i, (i < got_q.size()) ? got_q[i] : 0, exp_q[i]);
        else n_pass++;
      end
      n_checks++; if (sready_viol != 0) $display("FAIL stall_s_ready: got %0d cycles ready under stall expected 0", sready_viol); else n_pass++;
      n_checks++; if (hold_viol != 0) $display("FAIL stall_hold: got %0d unstable cycles expected 0", hold_viol); else n_pass++;
      n_checks++; if (done_cnt != 1) $display("FAIL stall_done[m%0d]: got %0d pulses expected 1", mode, done_cnt); else n_pass++;
    end
  endtask

  task automatic test_ignore_start_mode;
    fill_random();
    build_expected(1);
    run_frame(2'b01, 10, -1, -1, 1);
    n_checks++; if (got_q.size() != NOUT) $display("FAIL ignore_count: got %0d expected %0d", got_q.size(), NOUT); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL ignore_pixel[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : 0, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL ignore_done: got %0d pulses expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_abort;
    int bad;
    fill_random();
    run_frame(2'b00, 20, -1, 30, 0);
    @(negedge clk);
    n_checks++; if (!aborted) $display("FAIL abort_reached: got 0 expected 1"); else n_pass++;
    n_checks++; if (m_valid !== 1'b0) $display("FAIL abort_m_valid: got %0b expected 0", m_valid); else n_pass++;
    n_checks++; if (m_data !== '0) $display("FAIL abort_m_data: got %0d expected 0", m_data); else n_pass++;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL abort_s_ready: got %0b expected 0", s_ready); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL abort_busy: got %0b expected 0", busy_o); else n_pass++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_valid || done_o || busy_o) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); else n_pass++;
    fill_random();
    build_expected(3);
    run_frame(2'b11, 15, -1, -1, 0);
    n_checks++; if (got_q.size() != NOUT) $display("FAIL after_abort_count: got %0d expected %0d", got_q.size(), NOUT); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL after_abort_pixel[%0d]: got %0d expected %0d", i, (i < got_q.size()) ? got_q[i] : 0, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (done_cnt != 1) $display("FAIL after_abort_done: got %0d pulses expected 1", done_cnt); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_gauss_const();
    test_sobel_edge();
    test_ramp_mag();
    test_stall_random();
    test_ignore_start_mode();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kernel_conv_engine.md
KERNEL_CONV_ENGINE -- requirements
Module: kernel_conv_engine

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 512, pixels per row (>=3).
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 512, rows per frame (>=3).
REQ-003 SHALL have parameter PIXEL_W, default 8, pixel bit width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start_i  input  1  one-cycle frame start request.
REQ-007 SHALL have port mode_i  input  2  00 gaussian, 01 |sobel_x|, 10 |sobel_y|, 11 |gx|+|gy|.
REQ-008 SHALL have port s_valid  input  1  input pixel valid.
REQ-009 SHALL have port s_ready  output  1  engine accepts input pixel.
REQ-010 SHALL have port s_data  input  PIXEL_W  input pixel, raster order.
REQ-011 SHALL have port m_valid  output  1  output pixel valid.
REQ-012 SHALL have port m_ready  input  1  downstream accepts output.
REQ-013 SHALL have port m_data  output  PIXEL_W  filtered pixel.
REQ-014 SHALL have port busy_o  output  1  frame in progress (state != IDLE).
REQ-015 SHALL have port done_o  output  1  one-cycle pulse after last output handshake.

Function
REQ-016 SHALL implement FSM IDLE -> RUN on start_i; RUN -> FLUSH on acceptance of pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1); FLUSH -> IDLE on handshake of last output.
REQ-017 SHALL sample mode_i only in IDLE on start_i; mode_i changes during RUN/FLUSH ignored.
REQ-018 SHALL ignore start_i while busy_o=1.
REQ-019 SHALL transfer input on s_valid && s_ready, output on m_valid && m_ready; no other transfer.
REQ-020 SHALL drive s_ready = (state==RUN) && (!m_valid || m_ready); any output stall freezes the whole pipeline.
REQ-021 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-022 SHALL keep column/row counters wrapping col at IMAGE_WIDTH-1 -> 0 with row increment.
REQ-023 SHALL buffer two previous rows (IMAGE_WIDTH entries each) plus a 3x3 window register.
REQ-024 SHALL emit one output per accepted pixel with row>=2 and col>=2, centred at (row-1,col-1); no border padding; (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2) outputs per frame.
REQ-025 SHALL present m_valid exactly 2 cycles after the qualifying input handshake absent stalls (compute stage + output register).
REQ-026 SHALL compute gaussian as weighted sum with kernel 1 2 1 / 2 4 2 / 1 2 1 at PIXEL_W+4 bits, result = sum >> 4 (truncate).
REQ-027 SHALL compute gx, gy signed at PIXEL_W+3 bits with kernels -1 0 1 / -2 0 2 / -1 0 1 and its transpose (-1 -2 -1 / 0 0 0 / 1 2 1).
REQ-028 SHALL saturate sobel modes to 2^PIXEL_W-1: |gx|, |gy|, or |gx|+|gy|.
REQ-029 SHALL not require s_valid during FLUSH; FLUSH ends only when all pipeline outputs are handshaken.
REQ-030 SHALL pulse done_o in the cycle after the final output handshake, coincident with busy_o falling.

Reset
REQ-031 SHALL on rst_n=0 at clock edge set state IDLE, counters 0, pipeline valids 0, m_valid 0, m_data 0, s_ready 0, busy_o 0, done_o 0, mode register 00.
REQ-032 SHALL treat reset mid-frame as frame abort: no further outputs, no done_o; line buffer contents need not be cleared.

Structure
REQ-033 SHALL place IMAGE_HEIGHT, PIXEL_W, conv_mode_e enum (GAUSS, SOBEL_X, SOBEL_Y, SOBEL_MAG) and the three kernels in definitions_pkg.
REQ-034 SHALL factor the two-row line storage plus 3x3 window into sub-module conv_line_buffer (stall-aware enable).

Verification (bench IMAGE_WIDTH=8, IMAGE_HEIGHT=6)
REQ-035 Constant image 100, mode GAUSS, m_ready=1 -> 24 outputs all 100, done_o one pulse, first m_valid 2 cycles after pixel (2,2) accepted.
REQ-036 Columns 0-3 = 0, 4-7 = 200, SOBEL_X -> output cols 2,3 (centres 3,4) = 255 saturated, others 0; SOBEL_Y -> all 0.
REQ-037 Ramp pixel=row*10, SOBEL_MAG -> all outputs 80 (gy=80, gx=0).
REQ-038 Random image, m_ready low 10 cycles mid-frame -> s_ready low same cycles, m_data held, output sequence equals golden model, still 24 outputs.
REQ-039 start_i and mode_i toggled during RUN -> ignored, results match original mode; rst_n low 1 cycle mid-frame -> all outputs 0 next cycle, no done_o, next frame correct.
